// File: rtl/mem_ifm_pingpong.sv
// Ping-pong IFM store: sparsemap bit plus nonzero-data byte per element.
// The loader fills the write bank from a valid/ready beat stream while the
// PE array reads the opposite bank by chunk/beat index. Banks exchange roles
// once the write bank is complete and the read bank is free or released.
module mem_ifm_pingpong #(
  parameter  int unsigned BUS_SIZE   = 32,
  parameter  int unsigned CHUNK_SIZE = 128,
  parameter  int unsigned CHUNK_NUM  = 12,
  localparam int unsigned DAT_CYC    = CHUNK_SIZE / BUS_SIZE,
  localparam int unsigned CHUNK_W    = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1,
  localparam int unsigned DAT_W      = (DAT_CYC > 1) ? $clog2(DAT_CYC) : 1,
  localparam int unsigned NUM_W      = $clog2(CHUNK_NUM + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BUS_SIZE-1:0]       wr_sparsemap_i,
  input  logic [BUS_SIZE-1:0][7:0]  wr_nonzero_data_i,
  input  logic                      wr_valid_i,
  input  logic                      wr_last_i,
  output logic                      wr_ready_o,
  input  logic                      rd_en_i,
  input  logic [CHUNK_W-1:0]        rd_chunk_i,
  input  logic [DAT_W-1:0]          rd_dat_i,
  output logic [BUS_SIZE-1:0]       rd_sparsemap_o,
  output logic [BUS_SIZE-1:0][7:0]  rd_nonzero_data_o,
  output logic                      rd_valid_o,
  output logic                      rd_oor_o,
  output logic                      rd_bank_ready_o,
  output logic [NUM_W-1:0]          rd_chunk_num_o,
  input  logic                      rd_release_i
);

  // Beat dimension padded to a power of two so any rd_dat_i stays in range.
  localparam int unsigned DAT_DEPTH = 1 << DAT_W;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } wr_state_e;

  wr_state_e state_q, state_d;
  logic      wr_ready_q, wr_ready_d;

  logic               wr_bank_q;
  logic [DAT_W-1:0]   dat_cnt_q;
  logic [CHUNK_W-1:0] chunk_cnt_q;
  logic [NUM_W-1:0]   fill_num_q;
  logic               rd_bank_ready_q;
  logic [NUM_W-1:0]   rd_chunk_num_q;

  logic                     rd_valid_q;
  logic                     rd_oor_q;
  logic [BUS_SIZE-1:0]      rd_sm_q;
  logic [BUS_SIZE-1:0][7:0] rd_nz_q;

  logic [BUS_SIZE-1:0]      sm_mem [2][CHUNK_NUM][DAT_DEPTH];
  logic [BUS_SIZE-1:0][7:0] nz_mem [2][CHUNK_NUM][DAT_DEPTH];

  logic wr_accept;
  logic beat_wrap;
  logic chunk_end;
  logic bank_done;
  logic swap;
  logic rd_bank;
  logic rd_bad;

  // Handshake, bank-complete, swap and read-validity decode
  always_comb begin
    wr_accept = wr_valid_i & wr_ready_q;
    beat_wrap = (dat_cnt_q == DAT_W'(DAT_CYC - 1));
    chunk_end = (chunk_cnt_q == CHUNK_W'(CHUNK_NUM - 1));
    bank_done = wr_accept & beat_wrap & (chunk_end | wr_last_i);
    swap      = (state_q == ST_HOLD) & (~rd_bank_ready_q | rd_release_i);
    rd_bank   = ~wr_bank_q;
    rd_bad    = ~rd_bank_ready_q | (NUM_W'(rd_chunk_i) >= rd_chunk_num_q);
  end

  // Write FSM state register; wr_ready is registered alongside the state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_FILL;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Write FSM next state: close bank on its final beat, reopen on swap
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (bank_done) state_d = ST_HOLD;
      ST_HOLD: if (swap)      state_d = ST_FILL;
      default:                state_d = ST_FILL;
    endcase
  end

  // Write FSM output: accept beats whenever the next state is FILL
  always_comb begin
    wr_ready_d = 1'b0;
    if (state_d == ST_FILL) wr_ready_d = 1'b1;
  end

  // Bank roles, fill counters and read-bank status
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q       <= 1'b0;
      dat_cnt_q       <= '0;
      chunk_cnt_q     <= '0;
      fill_num_q      <= '0;
      rd_bank_ready_q <= 1'b0;
      rd_chunk_num_q  <= '0;
    end else if (swap) begin
      wr_bank_q       <= ~wr_bank_q;
      rd_bank_ready_q <= 1'b1;
      rd_chunk_num_q  <= fill_num_q;
      dat_cnt_q       <= '0;
      chunk_cnt_q     <= '0;
    end else begin
      if (rd_release_i && rd_bank_ready_q) begin
        rd_bank_ready_q <= 1'b0;
        rd_chunk_num_q  <= '0;
      end
      if (wr_accept) begin
        if (beat_wrap) begin
          dat_cnt_q   <= '0;
          chunk_cnt_q <= bank_done ? '0 : chunk_cnt_q + CHUNK_W'(1);
        end else begin
          dat_cnt_q <= dat_cnt_q + DAT_W'(1);
        end
      end
      if (bank_done) fill_num_q <= NUM_W'(chunk_cnt_q) + NUM_W'(1);
    end
  end

  // Storage write port into the current write bank (contents not reset)
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      sm_mem[wr_bank_q][chunk_cnt_q][dat_cnt_q] <= wr_sparsemap_i;
      nz_mem[wr_bank_q][chunk_cnt_q][dat_cnt_q] <= wr_nonzero_data_i;
    end
  end

  // Registered read port; invalid reads return zero data with rd_oor set
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_sm_q    <= '0;
      rd_nz_q    <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      rd_oor_q   <= rd_en_i & rd_bad;
      if (rd_en_i) begin
        if (rd_bad) begin
          rd_sm_q <= '0;
          rd_nz_q <= '0;
        end else begin
          rd_sm_q <= sm_mem[rd_bank][rd_chunk_i][rd_dat_i];
          rd_nz_q <= nz_mem[rd_bank][rd_chunk_i][rd_dat_i];
        end
      end
    end
  end

  assign wr_ready_o        = wr_ready_q;
  assign rd_sparsemap_o    = rd_sm_q;
  assign rd_nonzero_data_o = rd_nz_q;
  assign rd_valid_o        = rd_valid_q;
  assign rd_oor_o          = rd_oor_q;
  assign rd_bank_ready_o   = rd_bank_ready_q;
  assign rd_chunk_num_o    = rd_chunk_num_q;

endmodule

// File: tb/tb_mem_ifm_pingpong.sv
// Directed testbench for mem_ifm_pingpong (3 chunks x 4 beats per bank).
module tb_mem_ifm_pingpong;

  localparam int unsigned BUS_SIZE   = 32;
  localparam int unsigned CHUNK_SIZE = 128;
  localparam int unsigned CHUNK_NUM  = 3;
  localparam int unsigned RW         = 2 + BUS_SIZE + BUS_SIZE * 8;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [BUS_SIZE-1:0]      wr_sparsemap_i;
  logic [BUS_SIZE-1:0][7:0] wr_nonzero_data_i;
  logic                     wr_valid_i;
  logic                     wr_last_i;
  logic                     wr_ready_o;
  logic                     rd_en_i;
  logic [1:0]               rd_chunk_i;
  logic [1:0]               rd_dat_i;
  logic [BUS_SIZE-1:0]      rd_sparsemap_o;
  logic [BUS_SIZE-1:0][7:0] rd_nonzero_data_o;
  logic                     rd_valid_o;
  logic                     rd_oor_o;
  logic                     rd_bank_ready_o;
  logic [1:0]               rd_chunk_num_o;
  logic                     rd_release_i;

  int checks = 0;
  int errors = 0;

  wire [RW-1:0] rd_word = {rd_valid_o, rd_oor_o, rd_sparsemap_o, rd_nonzero_data_o};
  logic [RW-1:0] exp_word;

  mem_ifm_pingpong #(
    .BUS_SIZE  (BUS_SIZE),
    .CHUNK_SIZE(CHUNK_SIZE),
    .CHUNK_NUM (CHUNK_NUM)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wr_sparsemap_i   (wr_sparsemap_i),
    .wr_nonzero_data_i(wr_nonzero_data_i),
    .wr_valid_i       (wr_valid_i),
    .wr_last_i        (wr_last_i),
    .wr_ready_o       (wr_ready_o),
    .rd_en_i          (rd_en_i),
    .rd_chunk_i       (rd_chunk_i),
    .rd_dat_i         (rd_dat_i),
    .rd_sparsemap_o   (rd_sparsemap_o),
    .rd_nonzero_data_o(rd_nonzero_data_o),
    .rd_valid_o       (rd_valid_o),
    .rd_oor_o         (rd_oor_o),
    .rd_bank_ready_o  (rd_bank_ready_o),
    .rd_chunk_num_o   (rd_chunk_num_o),
    .rd_release_i     (rd_release_i)
  );

  always #5 clk_i = ~clk_i;

  // Beat k of tile 'tag' carries a pattern unique to (tag, k)
  function automatic logic [BUS_SIZE-1:0] pat_sm(input int tag, input int k);
    return {8'(tag), 8'(k), 8'(tag ^ 255), 8'(k * 3 + 1)};
  endfunction

  function automatic logic [BUS_SIZE-1:0][7:0] pat_dat(input int tag, input int k);
    logic [BUS_SIZE-1:0][7:0] d;
    for (int i = 0; i < BUS_SIZE; i++) d[i] = 8'(tag * 37 + k * 7 + i + 1);
    return d;
  endfunction

  function automatic logic [RW-1:0] good_word(input int tag, input int k);
    return {1'b1, 1'b0, pat_sm(tag, k), pat_dat(tag, k)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_read(input int c, input int d);
    rd_en_i    = 1'b1;
    rd_chunk_i = 2'(c);
    rd_dat_i   = 2'(d);
    tick();
    rd_en_i    = 1'b0;
  endtask

  task automatic pulse_release();
    rd_release_i = 1'b1;
    tick();
    rd_release_i = 1'b0;
  endtask

  // Streams n beats of tile 'tag'; bit k of last_mask drives wr_last_i on beat k
  task automatic write_tile(input int tag, input int n, input int last_mask);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (wr_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL wr_ready_beat tag=%0d beat=%0d got=%b exp=1", tag, k, wr_ready_o);
      end
      wr_valid_i        = 1'b1;
      wr_sparsemap_i    = pat_sm(tag, k);
      wr_nonzero_data_i = pat_dat(tag, k);
      wr_last_i         = last_mask[k];
      tick();
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; wr_valid_i = 1'b0; wr_last_i = 1'b0; rd_en_i = 1'b0;
    rd_chunk_i = '0; rd_dat_i = '0; rd_release_i = 1'b0;
    wr_sparsemap_i = '0; wr_nonzero_data_i = '0;
    tick(); tick();
    checks++;
    if ({wr_ready_o, rd_bank_ready_o, rd_chunk_num_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_status got=%b exp=1000", {wr_ready_o, rd_bank_ready_o, rd_chunk_num_o});
    end
    checks++;
    if (rd_word !== '0) begin
      errors++;
      $display("FAIL reset_read got=%h exp=0", rd_word);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_full_fill();
    write_tile(1, 12, 0);
    checks++;
    if ({wr_ready_o, rd_bank_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL fill_hold got=%b exp=00", {wr_ready_o, rd_bank_ready_o});
    end
    tick();
    checks++;
    if ({wr_ready_o, rd_bank_ready_o, rd_chunk_num_o} !== 4'b1111) begin
      errors++;
      $display("FAIL fill_swap got=%b exp=1111", {wr_ready_o, rd_bank_ready_o, rd_chunk_num_o});
    end
    issue_read(1, 2);
    exp_word = good_word(1, 6);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL fill_read_c1d2 got=%h exp=%h", rd_word, exp_word);
    end
    tick();
    exp_word = {2'b00, pat_sm(1, 6), pat_dat(1, 6)};
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL idle_hold_data got=%h exp=%h", rd_word, exp_word);
    end
  endtask

  task automatic test_back_to_back();
    write_tile(2, 12, 0);
    tick(); tick(); tick();
    checks++;
    if ({wr_ready_o, rd_bank_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL stall_no_release got=%b exp=01", {wr_ready_o, rd_bank_ready_o});
    end
    issue_read(0, 0);
    exp_word = good_word(1, 0);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL stall_bankA_read got=%h exp=%h", rd_word, exp_word);
    end
    pulse_release();
    checks++;
    if ({wr_ready_o, rd_bank_ready_o, rd_chunk_num_o} !== 4'b1111) begin
      errors++;
      $display("FAIL release_swap got=%b exp=1111", {wr_ready_o, rd_bank_ready_o, rd_chunk_num_o});
    end
    issue_read(2, 3);
    exp_word = good_word(2, 11);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL bankB_read_c2d3 got=%h exp=%h", rd_word, exp_word);
    end
  endtask

  task automatic test_partial_tile();
    write_tile(3, 4, 32'b1010);
    tick();
    checks++;
    if (wr_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL partial_hold got=%b exp=0", wr_ready_o);
    end
    pulse_release();
    checks++;
    if ({rd_bank_ready_o, rd_chunk_num_o} !== 3'b101) begin
      errors++;
      $display("FAIL partial_num got=%b exp=101", {rd_bank_ready_o, rd_chunk_num_o});
    end
    issue_read(0, 3);
    exp_word = good_word(3, 3);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL partial_read_c0d3 got=%h exp=%h", rd_word, exp_word);
    end
    issue_read(1, 0);
    exp_word = {2'b11, {(RW - 2){1'b0}}};
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL oor_chunk1 got=%h exp=%h", rd_word, exp_word);
    end
    issue_read(2, 1);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL oor_chunk2 got=%h exp=%h", rd_word, exp_word);
    end
  endtask

  task automatic test_release_idle();
    pulse_release();
    checks++;
    if ({wr_ready_o, rd_bank_ready_o, rd_chunk_num_o} !== 4'b1000) begin
      errors++;
      $display("FAIL release_clear got=%b exp=1000", {wr_ready_o, rd_bank_ready_o, rd_chunk_num_o});
    end
    issue_read(0, 0);
    exp_word = {2'b11, {(RW - 2){1'b0}}};
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL read_not_ready got=%h exp=%h", rd_word, exp_word);
    end
    pulse_release();
    checks++;
    if ({wr_ready_o, rd_bank_ready_o, rd_chunk_num_o} !== 4'b1000) begin
      errors++;
      $display("FAIL release_ignored got=%b exp=1000", {wr_ready_o, rd_bank_ready_o, rd_chunk_num_o});
    end
  endtask

  task automatic test_read_on_swap();
    write_tile(4, 12, 0);
    tick();
    checks++;
    if ({rd_bank_ready_o, rd_chunk_num_o} !== 3'b111) begin
      errors++;
      $display("FAIL auto_swap got=%b exp=111", {rd_bank_ready_o, rd_chunk_num_o});
    end
    write_tile(5, 12, 0);
    tick();
    rd_release_i = 1'b1;
    issue_read(0, 1);
    rd_release_i = 1'b0;
    exp_word = good_word(4, 1);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL swap_cycle_old_bank got=%h exp=%h", rd_word, exp_word);
    end
    checks++;
    if (wr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL swap_cycle_ready got=%b exp=1", wr_ready_o);
    end
    issue_read(0, 1);
    exp_word = good_word(5, 1);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL post_swap_new_bank got=%h exp=%h", rd_word, exp_word);
    end
  endtask

  task automatic test_async_reset();
    write_tile(6, 5, 0);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({wr_ready_o, rd_bank_ready_o, rd_chunk_num_o} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset_status got=%b exp=1000", {wr_ready_o, rd_bank_ready_o, rd_chunk_num_o});
    end
    checks++;
    if (rd_word !== '0) begin
      errors++;
      $display("FAIL async_reset_read got=%h exp=0", rd_word);
    end
    tick();
    rst_i = 1'b0;
    tick();
    write_tile(7, 12, 0);
    tick();
    issue_read(0, 0);
    exp_word = good_word(7, 0);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL refill_c0d0 got=%h exp=%h", rd_word, exp_word);
    end
    issue_read(1, 1);
    exp_word = good_word(7, 5);
    checks++;
    if (rd_word !== exp_word) begin
      errors++;
      $display("FAIL refill_c1d1 got=%h exp=%h", rd_word, exp_word);
    end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_back_to_back();
    test_partial_tile();
    test_release_idle();
    test_read_on_swap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ifm_pingpong.md
Name: mem_ifm_pingpong

Overview:
Double-buffered (ping-pong) IFM store holding a sparsemap bit and a nonzero-data byte per element, with two banks of CHUNK_NUM chunks each.
The loader fills the write bank through a valid/ready stream using internal address counters. The PE array reads the other bank by chunk/beat index with registered output.
Banks swap under handshake control, so DMA fill of the next IFM tile overlaps compute on the current one. Early bank close supports partial tiles.

Parameters:
BUS_SIZE, 32, elements per bus beat (sparsemap bits / data bytes)
CHUNK_SIZE, 128, elements per chunk; must be a multiple of BUS_SIZE
CHUNK_NUM, 12, maximum chunks per bank
DAT_CYC (localparam), CHUNK_SIZE/BUS_SIZE, beats per chunk

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
wr_sparsemap_i  in  BUS_SIZE  sparsemap beat
wr_nonzero_data_i  in  BUS_SIZE*8  data beat (packed [BUS_SIZE][8])
wr_valid_i  in  1  write beat valid
wr_last_i  in  1  close bank after this chunk (partial tile)
wr_ready_o  out  1  write bank can accept a beat
rd_en_i  in  1  read request
rd_chunk_i  in  clog2(CHUNK_NUM)  chunk index
rd_dat_i  in  clog2(DAT_CYC) (min 1)  beat index within chunk
rd_sparsemap_o  out  BUS_SIZE  read sparsemap
rd_nonzero_data_o  out  BUS_SIZE*8  read data
rd_valid_o  out  1  read data valid
rd_oor_o  out  1  read was invalid (bank not ready or chunk out of range)
rd_bank_ready_o  out  1  read bank holds a complete tile
rd_chunk_num_o  out  clog2(CHUNK_NUM+1)  valid chunks in read bank
rd_release_i  in  1  consumer has finished the read bank

Behaviour:
- Reset (async assert, sync release): write FSM=FILL, wr_ready_o=1, write bank=0; counters dat_cnt=chunk_cnt=0; rd_valid_o=0, rd_oor_o=0, rd_sparsemap_o=0, rd_nonzero_data_o=0, rd_bank_ready_o=0, rd_chunk_num_o=0. Array contents are not reset. Reset mid-fill discards the partial tile.
- Write accept: wr_valid_i & wr_ready_o. Beat goes to write bank [chunk_cnt][BUS_SIZE*dat_cnt +: BUS_SIZE]. dat_cnt increments, wrapping at DAT_CYC-1; on wrap chunk_cnt increments.
- Bank complete: accepted beat with dat_cnt==DAT_CYC-1 and either chunk_cnt==CHUNK_NUM-1 or wr_last_i. Latch fill_num=chunk_cnt+1; FSM goes FILL->HOLD. wr_last_i is ignored on any other beat.
- HOLD: wr_ready_o=0. Swap fires in HOLD when !rd_bank_ready_o or rd_release_i (both in the same cycle is legal).
- On swap: bank roles exchange, rd_bank_ready_o<=1, rd_chunk_num_o<=fill_num, counters<=0, FSM<=FILL, so wr_ready_o=1 in the next cycle. Minimum: last beat at cycle N, HOLD at N+1, rd_bank_ready_o=1 at N+2.
- rd_release_i with no swap that cycle: rd_bank_ready_o<=0, rd_chunk_num_o<=0. rd_release_i while rd_bank_ready_o=0 is ignored.
- Read: 1-cycle latency. rd_en_i at cycle N gives rd_valid_o=1 at N+1, with data from the bank that was the read bank at N (pre-swap if a swap fires at N). With no rd_en_i, rd_valid_o=0 and data holds its last value.
- Invalid read: rd_bank_ready_o=0 or rd_chunk_i>=rd_chunk_num_o. Still rd_valid_o=1 at N+1, with rd_oor_o=1 and zero data. rd_oor_o is otherwise 0.
- Reads and writes target different banks and never collide. Read and write in the same cycle are fully concurrent.

Test Plan:
(Params BUS_SIZE=32, CHUNK_SIZE=128, CHUNK_NUM=3 -> DAT_CYC=4.)
1. Reset, then stream 12 beats with value k on beat k -> wr_ready_o=0 after beat 11; rd_bank_ready_o=1 two cycles later; rd_chunk_num_o=3; reading chunk1/dat2 returns pattern 6, one cycle after rd_en_i.
2. Start a second tile while bank A is being read; stall after 12 beats with no release -> wr_ready_o stays 0 and bank A reads are unchanged. Pulse rd_release_i -> swap in that cycle; bank B data appears; wr_ready_o=1 the next cycle.
3. wr_last_i on beat 3 (end of chunk 0) -> rd_chunk_num_o=1. Read chunk 2 -> rd_oor_o=1 and zero data. wr_last_i on beat 1 -> ignored.
4. rd_en_i with rd_bank_ready_o=0 -> rd_valid_o=1, rd_oor_o=1, zero data. rd_release_i with no tile loaded -> no state change.
5. rd_en_i in the same cycle a swap fires -> old-bank data returned. The next read returns new-bank data.
6. Assert rst_i asynchronously after 5 beats -> wr_ready_o=1, rd_bank_ready_o=0, counters 0 immediately. Refill 12 beats -> data of chunk0 is fresh.
